// File: rtl/vga_timing_pkg.sv
// +--------------------------------------------------------------------+
// | vga_timing_pkg : 640x480@60 timing constants and monitor states    |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package vga_timing_pkg;

  localparam int VGA_H_TOTAL = 800;
  localparam int VGA_V_TOTAL = 521;
  localparam int VGA_H_SYNC  = 96;
  localparam int VGA_V_SYNC  = 2;
  localparam int VGA_HBP     = 144;
  localparam int VGA_HFP     = 784;
  localparam int VGA_VBP     = 31;
  localparam int VGA_VFP     = 511;

  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] CHECK  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_sync_edge.sv
// +--------------------------------------------------------------------+
// | vga_sync_edge : registered sync copy with fall/rise pulses         |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module vga_sync_edge (
  input  logic clk,
  input  logic clr,
  input  logic sync_in,
  output logic fall,
  output logic rise
);

  logic r_sync_d;

  // Reset to the idle (high) level so a low input after reset reads as an edge.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_sync_d <= 1'b1;
    else     r_sync_d <= sync_in;
  end

  assign fall = r_sync_d & ~sync_in;
  assign rise = ~r_sync_d & sync_in;

endmodule

`default_nettype wire

// File: rtl/vga_sync_monitor.sv
// +--------------------------------------------------------------------+
// | vga_sync_monitor : VGA sync receiver, timing recovery and lock     |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module vga_sync_monitor
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL     = VGA_H_TOTAL,
  parameter int V_TOTAL     = VGA_V_TOTAL,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int HBP         = VGA_HBP,
  parameter int HFP         = VGA_HFP,
  parameter int VBP         = VGA_VBP,
  parameter int VFP         = VGA_VFP,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [9:0] hc,
  output logic [9:0] vc,
  output logic       vidon,
  output logic       locked,
  output logic [9:0] line_len,
  output logic [9:0] frame_lines,
  output logic       err,
  output logic [7:0] err_cnt
);

  localparam logic [9:0] c_h_total = 10'(H_TOTAL);
  localparam logic [9:0] c_v_total = 10'(V_TOTAL);
  localparam logic [9:0] c_h_sync  = 10'(H_SYNC);
  localparam logic [9:0] c_v_sync  = 10'(V_SYNC);
  localparam logic [9:0] c_hbp     = 10'(HBP);
  localparam logic [9:0] c_hfp     = 10'(HFP);
  localparam logic [9:0] c_vbp     = 10'(VBP);
  localparam logic [9:0] c_vfp     = 10'(VFP);
  localparam logic [3:0] c_lock    = 4'(LOCK_FRAMES);

  logic       w_hfall, w_hrise, w_vfall, w_vrise;
  logic [9:0] r_vs_width;
  logic       r_line_bad, r_skip_len;
  logic [1:0] r_state, w_state_nx;
  logic [3:0] r_good_cnt, w_good_nx;

  vga_sync_edge u_hedge (.clk(clk), .clr(clr), .sync_in(hsync_in), .fall(w_hfall), .rise(w_hrise));
  vga_sync_edge u_vedge (.clk(clk), .clr(clr), .sync_in(vsync_in), .fall(w_vfall), .rise(w_vrise));

  // hc+1 is both the line length at hfall and the hsync width at hrise.
  logic [9:0] w_hc_inc, w_vs_meas, w_frame_meas;
  logic       w_bad_now, w_frame_ok, w_hc_miss, w_loss;

  assign w_hc_inc     = hc + 10'd1;
  assign w_vs_meas    = r_vs_width + {9'd0, w_hfall};
  assign w_frame_meas = w_hfall ? vc + 10'd1 : vc;

  assign w_bad_now = (r_state != SEARCH) &
                     ((w_hfall & ~r_skip_len & (w_hc_inc != c_h_total)) |
                      (w_hrise & (w_hc_inc != c_h_sync)) |
                      (w_vrise & (w_vs_meas != c_v_sync)));

  // A fault on the line closed by this vfall still belongs to the frame being judged.
  assign w_frame_ok = ~(r_line_bad | w_bad_now) & (w_frame_meas == c_v_total);
  assign w_hc_miss  = (hc == 10'd1022) & ~w_hfall;
  assign w_loss     = (r_state == LOCKED) &
                      (w_bad_now | (w_vfall & (w_frame_meas != c_v_total)) | w_hc_miss);

  always_comb begin
    w_state_nx = r_state;
    w_good_nx  = r_good_cnt;
    case (r_state)
      SEARCH: if (w_vfall) begin
        w_state_nx = CHECK;
        w_good_nx  = 4'd0;
      end
      CHECK: if (w_vfall) begin
        if (w_frame_ok) begin
          w_good_nx = r_good_cnt + 4'd1;
          if (w_good_nx == c_lock) w_state_nx = LOCKED;
        end else begin
          w_good_nx = 4'd0;
        end
      end
      LOCKED: if (w_loss) begin
        w_state_nx = SEARCH;
        w_good_nx  = 4'd0;
      end
      default: begin
        w_state_nx = SEARCH;
        w_good_nx  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      hc          <= 10'd0;
      vc          <= 10'd0;
      line_len    <= 10'd0;
      frame_lines <= 10'd0;
      r_vs_width  <= 10'd0;
      r_line_bad  <= 1'b0;
      r_skip_len  <= 1'b1;
      r_state     <= SEARCH;
      r_good_cnt  <= 4'd0;
      locked      <= 1'b0;
      err         <= 1'b0;
      err_cnt     <= 8'd0;
    end else begin
      hc <= w_hfall ? 10'd0 : sat_inc10(hc);
      if (w_hfall) line_len <= w_hc_inc;

      if (w_vfall) begin
        frame_lines <= w_frame_meas;
        vc          <= 10'd0;
      end else if (w_hfall) begin
        vc <= sat_inc10(vc);
      end

      // Count line starts inside the vsync pulse, including the one that ends it.
      if (w_vfall)                                r_vs_width <= 10'd0;
      else if (w_hfall & (~vsync_in | w_vrise))   r_vs_width <= sat_inc10(r_vs_width);

      if (w_vfall)        r_line_bad <= 1'b0;
      else if (w_bad_now) r_line_bad <= 1'b1;

      if (r_state == SEARCH) r_skip_len <= 1'b1;
      else if (w_hfall)      r_skip_len <= 1'b0;

      r_state    <= w_state_nx;
      r_good_cnt <= w_good_nx;
      locked     <= (w_state_nx == LOCKED);
      err        <= w_loss;
      if (w_loss && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

  assign vidon = locked & (hc > c_hbp) & (hc < c_hfp) & (vc > c_vbp) & (vc < c_vfp);

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_monitor.sv
// +--------------------------------------------------------------------+
// | tb_vga_sync_monitor : directed bench with a scaled sync generator  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_vga_sync_monitor;

  // Scaled-down mode keeps whole frames short enough to run many of them.
  localparam int HT = 40, VT = 12, HS = 6, VS = 2, HB = 10, HF = 36, VB = 3, VF = 10;

  logic       clk = 1'b0;
  logic       clr, hsync_in, vsync_in;
  logic [9:0] hc, vc, line_len, frame_lines;
  logic       vidon, locked, err;
  logic [7:0] err_cnt;

  int n_vec = 0, n_bad = 0;

  logic       gen_rst, hold_h, hold_v;
  int         gen_hlen, gen_vsw, gen_start_vc;
  logic [9:0] gen_hc, gen_vc, pg_hc, pg_vc;
  logic       vs_prev;

  always #5 clk = ~clk;

  vga_sync_monitor #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_SYNC(HS), .V_SYNC(VS),
    .HBP(HB), .HFP(HF), .VBP(VB), .VFP(VF), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .clr(clr), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hc(hc), .vc(vc), .vidon(vidon), .locked(locked),
    .line_len(line_len), .frame_lines(frame_lines), .err(err), .err_cnt(err_cnt)
  );

  // Reference source: free-running counters with syncs decoded from them.
  always_ff @(posedge clk) begin
    if (gen_rst) begin
      gen_hc <= 10'd0;
      gen_vc <= 10'(gen_start_vc);
    end else if (int'(gen_hc) >= gen_hlen - 1) begin
      gen_hc <= 10'd0;
      gen_vc <= (int'(gen_vc) >= VT - 1) ? 10'd0 : gen_vc + 10'd1;
    end else begin
      gen_hc <= gen_hc + 10'd1;
    end
    pg_hc   <= gen_hc;
    pg_vc   <= gen_vc;
    vs_prev <= vsync_in;
  end

  assign hsync_in = hold_h | (int'(gen_hc) >= HS);
  assign vsync_in = hold_v | (int'(gen_vc) >= gen_vsw);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Returns one negedge after the cycle in which the source presents a vsync fall.
  task automatic wait_vfall(input string tag);
    int   cyc;
    logic seen;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      seen = (vs_prev === 1'b1) && (vsync_in === 1'b0);
    end
    chk({tag, "_vfall_seen"}, 32'(seen), 1);
    @(negedge clk);
  endtask

  task automatic wait_gen(input int v, input int h, input string tag);
    int   cyc;
    logic seen;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      seen = (int'(gen_vc) == v) && (int'(gen_hc) == h);
    end
    chk({tag, "_reach"}, 32'(seen), 1);
  endtask

  initial begin
    int   a_err, v_err, v_on, cyc;
    logic exp_von, seen;

    clr = 1'b1; gen_rst = 1'b1; gen_hlen = HT; gen_vsw = VS; gen_start_vc = 8;
    hold_h = 1'b0; hold_v = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_hc", hc, 0);
    chk("rst_vc", vc, 0);
    chk("rst_locked", locked, 0);
    chk("rst_vidon", vidon, 0);
    chk("rst_err", err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_line_len", line_len, 0);
    chk("rst_frame_lines", frame_lines, 0);

    // Initial acquisition, source starts mid-frame.
    clr = 1'b0; gen_rst = 1'b0;
    wait_vfall("acq1"); chk("acq_locked_v1", locked, 0);
    wait_vfall("acq2"); chk("acq_locked_v2", locked, 0);
    wait_vfall("acq3"); chk("acq_locked_v3", locked, 1);
    chk("acq_hc_start", hc, 0);
    chk("acq_vc_start", vc, 0);
    chk("acq_line_len", line_len, HT);
    chk("acq_frame_lines", frame_lines, VT);
    chk("acq_err_cnt", err_cnt, 0);

    a_err = 0; v_err = 0; v_on = 0;
    repeat (HT * VT) begin
      @(negedge clk);
      exp_von = (int'(pg_hc) > HB) && (int'(pg_hc) < HF) && (int'(pg_vc) > VB) && (int'(pg_vc) < VF);
      if (hc !== pg_hc || vc !== pg_vc) a_err++;
      if (vidon !== exp_von) v_err++;
      if (vidon === 1'b1) v_on++;
    end
    chk("align_hc_vc", a_err, 0);
    chk("vidon_window", v_err, 0);
    chk("vidon_count", v_on, (HF - HB - 1) * (VF - VB - 1));

    // One line shortened by a clock.
    wait_gen(5, 5, "short");
    gen_hlen = HT - 1;
    wait_gen(6, 0, "short_wrap");
    gen_hlen = HT;
    @(negedge clk);
    chk("short_err", err, 1);
    chk("short_locked", locked, 0);
    chk("short_err_cnt", err_cnt, 1);
    chk("short_line_len", line_len, HT - 1);
    @(negedge clk);
    chk("short_err_pulse", err, 0);
    wait_vfall("rl1");
    wait_vfall("rl2"); chk("relock_v2", locked, 0);
    wait_vfall("rl3"); chk("relock_v3", locked, 1);
    chk("relock_err_cnt", err_cnt, 1);

    // Missing hsync; vsync held too so only the hc timeout can break lock.
    wait_gen(5, 20, "miss");
    hold_h = 1'b1; hold_v = 1'b1;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 1200) begin
      @(negedge clk);
      cyc++;
      seen = (err === 1'b1);
    end
    chk("miss_err_seen", 32'(seen), 1);
    chk("miss_hc", hc, 1023);
    chk("miss_locked", locked, 0);
    chk("miss_err_cnt", err_cnt, 2);
    repeat (40) @(negedge clk);
    chk("miss_hc_hold", hc, 1023);
    chk("miss_err_pulse", err, 0);
    wait_gen(5, 20, "miss_rel");
    hold_h = 1'b0; hold_v = 1'b0;

    // Three-line vsync during CHECK.
    wait_vfall("wv1");
    gen_vsw = 3;
    wait_gen(5, 0, "wv_restore");
    gen_vsw = VS;
    wait_vfall("wv2"); chk("wide_locked_v2", locked, 0);
    wait_vfall("wv3"); chk("wide_locked_v3", locked, 0);
    chk("wide_err_cnt", err_cnt, 2);
    wait_vfall("wv4"); chk("wide_locked_v4", locked, 1);

    // Asynchronous clear while locked.
    wait_gen(6, 15, "clr");
    clr = 1'b1;
    #1;
    chk("clr_hc", hc, 0);
    chk("clr_vc", vc, 0);
    chk("clr_locked", locked, 0);
    chk("clr_err_cnt", err_cnt, 0);
    chk("clr_vidon", vidon, 0);
    @(negedge clk);
    clr = 1'b0;
    wait_vfall("cl1");
    wait_vfall("cl2"); chk("clr_relock_v2", locked, 0);
    wait_vfall("cl3"); chk("clr_relock_v3", locked, 1);
    chk("clr_relock_err_cnt", err_cnt, 0);
    chk("clr_relock_frame_lines", frame_lines, VT);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
